instr_fetch_stage: RTL and testbench

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

---
 rtl/instr_fetch_stage.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC sequencing, branch/jump redirect, IF/ID latch, HALT/FAULT stop.
// Define FETCH_STATS_EN to build the fetch/redirect statistics counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | fetching: redirect > stall > sequential, one word per edge
// ST_HALT  | HALT_INSTR latched; PC frozen, IF/ID invalid after 1 cycle
// ST_FAULT | illegal redirect or fetch past LIMIT_PC; only rst_n exits
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] LIMIT_PC   = 32'h0040_0400,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] instr_in,
  output logic [31:0] currPC,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count,
  output logic [15:0] redirect_count
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redir_req;
  logic [31:0] redir_target;
  logic        redir_bad;
  logic [31:0] pc_plus4;

  function automatic logic target_bad(input logic [31:0] t);
    return (t[1:0] != 2'b00) || (t < RESET_PC) || (t > LIMIT_PC);
  endfunction

  // branch wins over jump when both are asserted
  assign redir_req    = branch_taken | jump;
  assign redir_target = branch_taken ? branch_target : jump_target;
  assign redir_bad    = target_bad(redir_target);
  assign pc_plus4     = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      ST_RUN: begin
        if (redir_req) begin
          valid_d = 1'b0;
          if (redir_bad) begin
            state_d = ST_FAULT;
          end else begin
            pc_d = redir_target;
          end
        end else if (!stall) begin
          instr_d = instr_in;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          if (instr_in == HALT_INSTR) begin
            state_d = ST_HALT;
          end else if (pc_q == LIMIT_PC) begin
            // top word is latched, but nothing past it may be fetched
            state_d = ST_FAULT;
            valid_d = 1'b0;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_FAULT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign currPC      = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);

`ifdef FETCH_STATS_EN
  logic        fetch_evt;
  logic        redirect_evt;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] redir_cnt_q, redir_cnt_d;

  assign fetch_evt    = (state_q == ST_RUN) && !redir_req && !stall;
  assign redirect_evt = (state_q == ST_RUN) && redir_req && !redir_bad;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (fetch_evt) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (redirect_evt && (redir_cnt_q != 16'hFFFF)) begin
      redir_cnt_d = redir_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign fetch_count    = fetch_cnt_q;
  assign redirect_count = redir_cnt_q;
`else
  assign fetch_count    = '0;
  assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: sequencing, stall, redirects, HALT, FAULT and reset.
module tb_instr_fetch_stage;

`ifdef FETCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr_in;
  logic [31:0] currPC;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;
  logic [15:0] redirect_count;

  int checks = 0;
  int errors = 0;

  instr_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .instr_in       (instr_in),
    .currPC         (currPC),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},     currPC, 32'h0040_0000);
    chk({tag, "_instr"},  if_id_instr, 32'h0);
    chk({tag, "_pc4"},    if_id_pc4, 32'h0);
    chk({tag, "_valid"},  {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_fault"},  {31'd0, fault}, 32'd0);
    chk({tag, "_fcnt"},   fetch_count, 32'd0);
    chk({tag, "_rcnt"},   {16'd0, redirect_count}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
    instr_in = 32'h2008_0001;
    step(); step();
    chk_reset("reset");

    // sequential fetch after reset release
    rst_n = 1'b1;
    step();
    chk("seq1_pc", currPC, 32'h0040_0004);
    chk("seq1_pc4", if_id_pc4, 32'h0040_0004);
    chk("seq1_instr", if_id_instr, 32'h2008_0001);
    chk("seq1_valid", {31'd0, if_id_valid}, 32'd1);
    step();
    chk("seq2_pc", currPC, 32'h0040_0008);
    chk("seq2_pc4", if_id_pc4, 32'h0040_0008);

    // three-cycle stall
    stall = 1'b1; instr_in = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", currPC, 32'h0040_0008);
      chk("stall_instr", if_id_instr, 32'h2008_0001);
      chk("stall_pc4", if_id_pc4, 32'h0040_0008);
      chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    chk("resume_pc", currPC, 32'h0040_000C);
    chk("resume_instr", if_id_instr, 32'h1111_1111);
    chk("resume_pc4", if_id_pc4, 32'h0040_000C);

    // branch and jump together: branch wins
    branch_taken = 1'b1; branch_target = 32'h0040_0040;
    jump = 1'b1; jump_target = 32'h0040_0080;
    step();
    chk("bj_pc", currPC, 32'h0040_0040);
    chk("bj_valid", {31'd0, if_id_valid}, 32'd0);
    chk("bj_instr", if_id_instr, 32'h1111_1111);
    chk("bj_fcnt", fetch_count, STATS_EN ? 32'd3 : 32'd0);
    chk("bj_rcnt", {16'd0, redirect_count}, STATS_EN ? 32'd1 : 32'd0);

    branch_taken = 1'b0; jump = 1'b0; instr_in = 32'h2222_2222;
    step(); step(); step();
    chk("seq3_pc", currPC, 32'h0040_004C);
    chk("seq3_pc4", if_id_pc4, 32'h0040_004C);
    chk("seq3_valid", {31'd0, if_id_valid}, 32'd1);

    jump = 1'b1; jump_target = 32'h0040_0010;
    step();
    chk("jmp_pc", currPC, 32'h0040_0010);
    chk("jmp_valid", {31'd0, if_id_valid}, 32'd0);
    chk("jmp_rcnt", {16'd0, redirect_count}, STATS_EN ? 32'd2 : 32'd0);

    // halt instruction at 0x00400010
    jump = 1'b0; instr_in = 32'h0000_000C;
    step();
    chk("halt_instr", if_id_instr, 32'h0000_000C);
    chk("halt_valid", {31'd0, if_id_valid}, 32'd1);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_pc", currPC, 32'h0040_0010);
    chk("halt_pc4", if_id_pc4, 32'h0040_0014);
    chk("halt_fcnt", fetch_count, STATS_EN ? 32'd7 : 32'd0);
    jump = 1'b1; jump_target = 32'h0040_0020; instr_in = 32'h3333_3333;
    step();
    chk("halt2_valid", {31'd0, if_id_valid}, 32'd0);
    chk("halt2_halted", {31'd0, halted}, 32'd1);
    chk("halt2_pc", currPC, 32'h0040_0010);
    chk("halt2_instr", if_id_instr, 32'h0000_000C);
    chk("halt2_fault", {31'd0, fault}, 32'd0);
    step();
    chk("halt3_pc", currPC, 32'h0040_0010);
    chk("halt3_halted", {31'd0, halted}, 32'd1);

    // reset out of HALT
    jump = 1'b0; rst_n = 1'b0;
    step();
    chk_reset("rst_halt");

    // redirect alongside HALT_INSTR cancels the halt
    rst_n = 1'b1; instr_in = 32'h0000_000C;
    branch_taken = 1'b1; branch_target = 32'h0040_0100;
    step();
    chk("cancel_pc", currPC, 32'h0040_0100);
    chk("cancel_halted", {31'd0, halted}, 32'd0);
    chk("cancel_valid", {31'd0, if_id_valid}, 32'd0);

    // misaligned jump target
    branch_taken = 1'b0; instr_in = 32'h2008_0001;
    jump = 1'b1; jump_target = 32'h0040_0002;
    step();
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_pc", currPC, 32'h0040_0100);
    chk("mis_valid", {31'd0, if_id_valid}, 32'd0);
    chk("mis_halted", {31'd0, halted}, 32'd0);
    jump_target = 32'h0040_0200;
    step();
    chk("mis_hold_fault", {31'd0, fault}, 32'd1);
    chk("mis_hold_pc", currPC, 32'h0040_0100);
    jump = 1'b0; rst_n = 1'b0;
    step();
    chk("rst_fault_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_pc", currPC, 32'h0040_0000);

    // jump above LIMIT_PC
    rst_n = 1'b1; jump = 1'b1; jump_target = 32'h0050_0000;
    step();
    chk("hi_fault", {31'd0, fault}, 32'd1);
    chk("hi_pc", currPC, 32'h0040_0000);
    jump = 1'b0; rst_n = 1'b0;
    step();

    // branch below RESET_PC
    rst_n = 1'b1; branch_taken = 1'b1; branch_target = 32'h003F_FFFC;
    step();
    chk("lo_fault", {31'd0, fault}, 32'd1);
    chk("lo_pc", currPC, 32'h0040_0000);
    branch_taken = 1'b0; rst_n = 1'b0;
    step();

    // jump to LIMIT_PC is legal; the fetch from it ends in FAULT
    rst_n = 1'b1; jump = 1'b1; jump_target = 32'h0040_0400;
    step();
    chk("lim_pc", currPC, 32'h0040_0400);
    chk("lim_fault0", {31'd0, fault}, 32'd0);
    jump = 1'b0; instr_in = 32'h4444_4444;
    step();
    chk("lim_instr", if_id_instr, 32'h4444_4444);
    chk("lim_pc4", if_id_pc4, 32'h0040_0404);
    chk("lim_pc_hold", currPC, 32'h0040_0400);
    chk("lim_fault", {31'd0, fault}, 32'd1);
    chk("lim_valid", {31'd0, if_id_valid}, 32'd0);
    instr_in = 32'h5555_5555;
    step();
    chk("lim2_instr", if_id_instr, 32'h4444_4444);
    chk("lim2_pc", currPC, 32'h0040_0400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
